otter_mem_responder: RTL and testbench

Memory-side responder for the OTTER multicycle MCU: services the control FSM's instruction-fetch read strobe (port 1) and data load/store strobes (port 2) from a word-organised on-chip RAM, with memory-mapped I/O above a fixed base address. It performs byte/half/word lane selection, sign/zero extension and byte-lane write merging. Optionally, it splits misaligned data accesses into two word cycles and stalls the requester with `MEM_BUSY`.

---
 rtl/otter_mem_responder.sv | 178 +++++++++++++++++
 tb/tb_otter_mem_responder.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_mem_responder.sv
// otter_mem_responder: memory-side responder for the OTTER multicycle MCU.
// Port 1 serves instruction fetches. Port 2 serves data loads and stores,
// with byte/half/word lane handling, and maps addresses at or above IO_BASE
// onto the I/O bus.
// Build option OTTER_MISALIGN_EN: when defined, a misaligned RAM access is
// split into two word cycles and MEM_BUSY is raised for the second cycle.
// When undefined, a misaligned RAM access is reported as an error.
module otter_mem_responder #(
  parameter int          DEPTH_WORDS = 16384,
  parameter logic [31:0] IO_BASE     = 32'h1100_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MEM_RDEN1,
  input  logic [31:0] MEM_ADDR1,
  output logic [31:0] MEM_DOUT1,
  input  logic        MEM_RDEN2,
  input  logic        MEM_WE2,
  input  logic [31:0] MEM_ADDR2,
  input  logic [31:0] MEM_DIN2,
  input  logic [1:0]  MEM_SIZE,
  input  logic        MEM_UNSIGNED,
  output logic [31:0] MEM_DOUT2,
  output logic        MEM_BUSY,
  output logic        MEM_ERR,
  input  logic [31:0] IOBUS_IN,
  output logic [31:0] IOBUS_ADDR,
  output logic [31:0] IOBUS_OUT,
  output logic        IOBUS_WR
);
  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH_WORDS);
  localparam logic [0:0]  ST_IDLE = 1'b0;
`ifdef OTTER_MISALIGN_EN
  localparam logic [0:0]  ST_SPLIT = 1'b1;
`endif

  logic [31:0] ram [DEPTH_WORDS];
  logic [0:0]  state;

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                         input logic uns);
    case (size)
      2'b00:   extend = uns ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'b01:   extend = uns ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: extend = raw;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] mask);
    merge = old;
    for (int i = 0; i < 4; i++)
      if (mask[i]) merge[8*i +: 8] = data[8*i +: 8];
  endfunction

  logic        req, is_wr, is_rd, is_io, size_bad, misal, a_oob, err_c;
  logic [29:0] idx_a, idx1;
  logic [1:0]  off;
  logic [3:0]  bmask, mask_lo;
  logic [31:0] word_a, rd_aligned, data_lo;
  logic        unused_addr1;

  assign req      = MEM_RDEN2 | MEM_WE2;
  assign is_wr    = MEM_WE2;
  assign is_rd    = MEM_RDEN2 & ~MEM_WE2;   // a write wins over a read
  assign is_io    = MEM_ADDR2 >= IO_BASE;
  assign idx_a    = MEM_ADDR2[31:2];
  assign idx1     = MEM_ADDR1[31:2];
  assign off      = MEM_ADDR2[1:0];
  assign size_bad = MEM_SIZE == 2'b11;
  assign misal    = (MEM_SIZE == 2'b01 && off[0]) || (MEM_SIZE == 2'b10 && off != 2'b00);
  assign a_oob    = idx_a >= DEPTH_W;
  assign bmask    = (MEM_SIZE == 2'b00) ? 4'b0001 : (MEM_SIZE == 2'b01) ? 4'b0011 : 4'b1111;
  assign word_a   = a_oob ? '0 : ram[idx_a[AW-1:0]];
  assign rd_aligned = extend(word_a >> {off, 3'b000}, MEM_SIZE, MEM_UNSIGNED);
  assign unused_addr1 = ^MEM_ADDR1[1:0];

`ifdef OTTER_MISALIGN_EN
  logic [29:0]   idx_b;
  logic          b_oob;
  logic [7:0]    mask8;
  logic [63:0]   data64;
  logic [AW-1:0] sp_idx_b;
  logic [3:0]    sp_mask_hi;
  logic [31:0]   sp_data_hi, sp_lo, split_raw;
  logic [1:0]    sp_off, sp_size;
  logic          sp_uns, sp_rd;

  assign idx_b   = idx_a + 30'd1;
  assign b_oob   = idx_b >= DEPTH_W;
  // The second word is range-checked up front so that a failing split writes neither half.
  assign err_c   = size_bad | (~is_io & (a_oob | (misal & b_oob)));
  // Lanes laid out across an 8-byte window {A+1, A}.
  assign mask8   = {4'b0, bmask} << off;
  assign data64  = {32'b0, MEM_DIN2} << {off, 3'b000};
  assign mask_lo = mask8[3:0];
  assign data_lo = data64[31:0];
  assign split_raw = 32'({ram[sp_idx_b], sp_lo} >> {sp_off, 3'b000});
  assign MEM_BUSY  = state == ST_SPLIT;

  // Capture the upper half of a potential split while idle; the requester holds its inputs.
  always_ff @(posedge CLK) begin
    if (state == ST_IDLE) begin
      sp_idx_b   <= idx_b[AW-1:0];
      sp_mask_hi <= mask8[7:4];
      sp_data_hi <= data64[63:32];
      sp_lo      <= word_a;
      sp_off     <= off;
      sp_size    <= MEM_SIZE;
      sp_uns     <= MEM_UNSIGNED;
      sp_rd      <= is_rd;
    end
  end
`else
  assign err_c   = size_bad | (~is_io & (a_oob | misal));
  assign mask_lo = bmask << off;
  assign data_lo = MEM_DIN2 << {off, 3'b000};
  assign MEM_BUSY = 1'b0;
`endif

  // RAM write port: word A on acceptance, word A+1 on the split cycle; nothing under reset.
  always_ff @(posedge CLK) begin
    if (!RST && state == ST_IDLE && req && is_wr && !err_c && !is_io)
      ram[idx_a[AW-1:0]] <= merge(word_a, data_lo, mask_lo);
`ifdef OTTER_MISALIGN_EN
    else if (!RST && state == ST_SPLIT && !sp_rd)
      ram[sp_idx_b] <= merge(ram[sp_idx_b], sp_data_hi, sp_mask_hi);
`endif
  end

  // Instruction fetch: independent of port 2; reads old data on a same-word write.
  always_ff @(posedge CLK) begin
    if (RST)            MEM_DOUT1 <= '0;
    else if (MEM_RDEN1) MEM_DOUT1 <= (idx1 >= DEPTH_W) ? '0 : ram[idx1[AW-1:0]];
  end

  // Port-2 control: acceptance, error and I/O strobes, load data register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      MEM_DOUT2  <= '0;
      MEM_ERR    <= 1'b0;
      IOBUS_ADDR <= '0;
      IOBUS_OUT  <= '0;
      IOBUS_WR   <= 1'b0;
    end else begin
      MEM_ERR  <= 1'b0;
      IOBUS_WR <= 1'b0;
      if (state == ST_IDLE) begin
        if (req) begin
          if (err_c) begin
            MEM_ERR <= 1'b1;
            if (is_rd) MEM_DOUT2 <= '0;
          end else if (is_io) begin
            if (is_wr) begin
              IOBUS_ADDR <= MEM_ADDR2;
              IOBUS_OUT  <= MEM_DIN2;
              IOBUS_WR   <= 1'b1;
            end else begin
              MEM_DOUT2 <= IOBUS_IN;
            end
          end
`ifdef OTTER_MISALIGN_EN
          else if (misal) state <= ST_SPLIT;
`endif
          else if (is_rd) MEM_DOUT2 <= rd_aligned;
        end
      end
`ifdef OTTER_MISALIGN_EN
      else begin
        state <= ST_IDLE;
        if (sp_rd) MEM_DOUT2 <= extend(split_raw, sp_size, sp_uns);
      end
`endif
    end
  end
endmodule

// File: tb/tb_otter_mem_responder.sv
// Bench for otter_mem_responder: directed scenarios plus randomized traffic
// checked against a byte-addressed memory model. Follows OTTER_MISALIGN_EN.
module tb_otter_mem_responder;
  localparam int          DEPTH   = 16384;
  localparam logic [31:0] IO_BASE = 32'h1100_0000;
`ifdef OTTER_MISALIGN_EN
  localparam bit MISAL = 1'b1;
`else
  localparam bit MISAL = 1'b0;
`endif

  logic        CLK = 1'b0, RST = 1'b1;
  logic        MEM_RDEN1 = 0, MEM_RDEN2 = 0, MEM_WE2 = 0, MEM_UNSIGNED = 0;
  logic [31:0] MEM_ADDR1 = 0, MEM_ADDR2 = 0, MEM_DIN2 = 0, IOBUS_IN = 0;
  logic [1:0]  MEM_SIZE = 0;
  logic [31:0] MEM_DOUT1, MEM_DOUT2, IOBUS_ADDR, IOBUS_OUT;
  logic        MEM_BUSY, MEM_ERR, IOBUS_WR;

  int n_chk = 0, n_fail = 0;
  logic [7:0] mb [0:DEPTH*4-1];

  otter_mem_responder #(.DEPTH_WORDS(DEPTH), .IO_BASE(IO_BASE)) dut (
    .CLK(CLK), .RST(RST),
    .MEM_RDEN1(MEM_RDEN1), .MEM_ADDR1(MEM_ADDR1), .MEM_DOUT1(MEM_DOUT1),
    .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2), .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2),
    .MEM_SIZE(MEM_SIZE), .MEM_UNSIGNED(MEM_UNSIGNED), .MEM_DOUT2(MEM_DOUT2),
    .MEM_BUSY(MEM_BUSY), .MEM_ERR(MEM_ERR), .IOBUS_IN(IOBUS_IN),
    .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT), .IOBUS_WR(IOBUS_WR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction
  function automatic bit m_misal(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
  endfunction
  function automatic bit m_err(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd3) return 1'b1;
    if (a >= IO_BASE) return 1'b0;
    if ((a >> 2) >= DEPTH) return 1'b1;
    if (m_misal(a, sz)) return MISAL ? (((a >> 2) + 1) >= DEPTH) : 1'b1;
    return 1'b0;
  endfunction
  function automatic logic [31:0] m_read(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    logic [31:0] v = 0;
    int n = nbytes(sz);
    for (int i = 0; i < n; i++) v = v | (32'(mb[a + i]) << (8 * i));
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction
  function automatic logic [31:0] m_word(input logic [31:0] a);
    logic [31:0] w = a & ~32'd3;
    return {mb[w+3], mb[w+2], mb[w+1], mb[w]};
  endfunction
  task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    for (int i = 0; i < nbytes(sz); i++) mb[a + i] = d[8*i +: 8];
  endtask

  // ---------------- drivers ----------------
  task automatic access(input logic we, input logic rd, input logic [31:0] addr,
                        input logic [31:0] din, input logic [1:0] sz, input logic uns,
                        input logic r1, input logic [31:0] a1,
                        output logic err_s, output logic iowr_s, output int nbusy);
    @(negedge CLK);
    MEM_WE2 = we; MEM_RDEN2 = rd; MEM_ADDR2 = addr; MEM_DIN2 = din;
    MEM_SIZE = sz; MEM_UNSIGNED = uns; MEM_RDEN1 = r1; MEM_ADDR1 = a1;
    @(posedge CLK); #1;
    err_s = MEM_ERR; iowr_s = IOBUS_WR; nbusy = 0;
    MEM_RDEN1 = 0;
    while (MEM_BUSY && nbusy < 4) begin
      nbusy++;
      @(posedge CLK); #1;
    end
    MEM_WE2 = 0; MEM_RDEN2 = 0;
  endtask

  task automatic mwr(input logic [31:0] addr, input logic [31:0] d);
    logic e, w; int nb;
    access(1, 0, addr, d, 2'd2, 0, 0, 0, e, w, nb);
    m_write(addr, d, 2'd2);
  endtask

  task automatic p1_read(input logic [31:0] addr, output logic [31:0] d);
    @(negedge CLK);
    MEM_RDEN1 = 1; MEM_ADDR1 = addr;
    @(posedge CLK); #1;
    d = MEM_DOUT1;
    MEM_RDEN1 = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1;
    repeat (2) @(posedge CLK);
    #1;
    n_chk++;
    if ({MEM_DOUT1, MEM_DOUT2, IOBUS_ADDR, IOBUS_OUT} !== 128'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h %h, expected all 0", MEM_DOUT1, MEM_DOUT2, IOBUS_ADDR, IOBUS_OUT);
    end
    n_chk++;
    if ({MEM_BUSY, MEM_ERR, IOBUS_WR} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got busy/err/wr %b, expected 000", {MEM_BUSY, MEM_ERR, IOBUS_WR});
    end
    @(negedge CLK);
    RST = 0;
  endtask

  task automatic test_word_byte();
    logic e, w; int nb;
    mwr(32'h100, 32'hDEAD_BEEF);
    access(0, 1, 32'h103, 0, 2'd0, 0, 1, 32'h100, e, w, nb);
    n_chk++;
    if (MEM_DOUT1 !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL fetch_word: got %h, expected DEADBEEF", MEM_DOUT1);
    end
    n_chk++;
    if (MEM_DOUT2 !== 32'hFFFF_FFDE) begin
      n_fail++; $display("FAIL byte_signed: got %h, expected FFFFFFDE", MEM_DOUT2);
    end
    access(0, 1, 32'h103, 0, 2'd0, 1, 0, 0, e, w, nb);
    n_chk++;
    if (MEM_DOUT2 !== 32'h0000_00DE) begin
      n_fail++; $display("FAIL byte_unsigned: got %h, expected 000000DE", MEM_DOUT2);
    end
  endtask

  task automatic test_half_merge();
    logic e, w; int nb; logic [31:0] d;
    mwr(32'h200, 32'hAABB_CCDD);
    access(1, 0, 32'h202, 32'h1234, 2'd1, 0, 0, 0, e, w, nb);
    m_write(32'h202, 32'h1234, 2'd1);
    p1_read(32'h200, d);
    n_chk++;
    if (d !== 32'h1234_CCDD) begin
      n_fail++; $display("FAIL half_merge: got %h, expected 1234CCDD", d);
    end
    access(0, 1, 32'h200, 0, 2'd1, 0, 0, 0, e, w, nb);
    n_chk++;
    if (MEM_DOUT2 !== 32'hFFFF_CCDD) begin
      n_fail++; $display("FAIL half_signed: got %h, expected FFFFCCDD", MEM_DOUT2);
    end
  endtask

  task automatic test_misalign();
    logic e, w; int nb; logic [31:0] d0, d1;
    mwr(32'h300, 32'h9999_9999);
    mwr(32'h304, 32'h8888_8888);
    access(1, 0, 32'h301, 32'h1122_3344, 2'd2, 0, 0, 0, e, w, nb);
    n_chk++;
    if (e !== !MISAL || nb != (MISAL ? 1 : 0)) begin
      n_fail++; $display("FAIL split_write_flags: got err=%b busy_cycles=%0d, expected err=%b busy_cycles=%0d",
                         e, nb, !MISAL, MISAL ? 1 : 0);
    end
    p1_read(32'h300, d0);
    p1_read(32'h304, d1);
    n_chk++;
    if ({d0, d1} !== (MISAL ? {32'h2233_4499, 32'h8888_8811} : {32'h9999_9999, 32'h8888_8888})) begin
      n_fail++; $display("FAIL split_write_words: got %h %h", d0, d1);
    end
    access(0, 1, 32'h301, 0, 2'd2, 0, 0, 0, e, w, nb);
    n_chk++;
    if (MEM_DOUT2 !== (MISAL ? 32'h1122_3344 : 32'h0) || nb != (MISAL ? 1 : 0)) begin
      n_fail++; $display("FAIL split_read: got %h busy_cycles=%0d", MEM_DOUT2, nb);
    end
    if (MISAL) begin
      m_write(32'h301, 32'h1122_3344, 2'd2);
    end
  endtask

  task automatic test_io();
    logic e, w; int nb;
    access(1, 0, IO_BASE, 32'd5, 2'd2, 0, 0, 0, e, w, nb);
    n_chk++;
    if (w !== 1'b1 || e !== 1'b0 || IOBUS_ADDR !== IO_BASE || IOBUS_OUT !== 32'd5) begin
      n_fail++; $display("FAIL io_write: got wr=%b err=%b addr=%h out=%h, expected 1 0 11000000 5",
                         w, e, IOBUS_ADDR, IOBUS_OUT);
    end
    @(posedge CLK); #1;
    n_chk++;
    if (IOBUS_WR !== 1'b0) begin
      n_fail++; $display("FAIL io_wr_pulse: got %b one cycle later, expected 0", IOBUS_WR);
    end
    IOBUS_IN = 32'd7;
    access(0, 1, IO_BASE + 32'h10, 0, 2'd0, 0, 0, 0, e, w, nb);
    n_chk++;
    if (MEM_DOUT2 !== 32'd7) begin
      n_fail++; $display("FAIL io_read: got %h, expected 7", MEM_DOUT2);
    end
  endtask

  task automatic test_errors();
    logic e, w; int nb; logic [31:0] d;
    mwr(32'h400, 32'h5555_5555);
    mwr(32'h0, 32'h0BAD_F00D);
    mwr(32'hFFFC, 32'h7777_7777);
    access(1, 0, 32'h400, 32'hFFFF_FFFF, 2'd3, 0, 0, 0, e, w, nb);
    n_chk++;
    if (e !== 1'b1) begin n_fail++; $display("FAIL size11_err: got %b, expected 1", e); end
    @(posedge CLK); #1;
    n_chk++;
    if (MEM_ERR !== 1'b0) begin n_fail++; $display("FAIL err_pulse: got %b, expected 0", MEM_ERR); end
    p1_read(32'h400, d);
    n_chk++;
    if (d !== 32'h5555_5555) begin n_fail++; $display("FAIL size11_nowrite: got %h, expected 55555555", d); end
    access(0, 1, 32'h400, 0, 2'd2, 0, 0, 0, e, w, nb);
    access(0, 1, 32'h400, 0, 2'd3, 0, 0, 0, e, w, nb);
    n_chk++;
    if (e !== 1'b1 || MEM_DOUT2 !== 32'd0) begin
      n_fail++; $display("FAIL size11_read: got err=%b data=%h, expected 1 0", e, MEM_DOUT2);
    end
    access(0, 1, 32'h400, 0, 2'd2, 0, 0, 0, e, w, nb);
    access(0, 1, 32'h1_0000, 0, 2'd2, 0, 0, 0, e, w, nb);
    n_chk++;
    if (e !== 1'b1 || MEM_DOUT2 !== 32'd0) begin
      n_fail++; $display("FAIL oob_read: got err=%b data=%h, expected 1 0", e, MEM_DOUT2);
    end
    access(1, 0, 32'h1_0000, 32'h1234_5678, 2'd2, 0, 0, 0, e, w, nb);
    p1_read(32'h0, d);
    n_chk++;
    if (e !== 1'b1 || d !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL oob_write: got err=%b word0=%h, expected 1 0BADF00D", e, d);
    end
    access(1, 0, 32'hFFFD, 32'hAAAA_AAAA, 2'd2, 0, 0, 0, e, w, nb);
    p1_read(32'hFFFC, d);
    n_chk++;
    if (e !== 1'b1 || nb != 0 || d !== 32'h7777_7777) begin
      n_fail++; $display("FAIL split_oob: got err=%b busy=%0d word=%h, expected 1 0 77777777", e, nb, d);
    end
    p1_read(32'h1_0000, d);
    n_chk++;
    if (d !== 32'd0 || MEM_ERR !== 1'b0) begin
      n_fail++; $display("FAIL fetch_oob: got data=%h err=%b, expected 0 0", d, MEM_ERR);
    end
  endtask

  task automatic test_rst_split();
    logic e, w; int nb; logic [31:0] d;
    mwr(32'h500, 32'h1111_1111);
    mwr(32'h504, 32'h2222_2222);
    access(0, 1, 32'h500, 0, 2'd2, 0, 1, 32'h504, e, w, nb);
    @(negedge CLK);
    MEM_WE2 = 1; MEM_ADDR2 = 32'h501; MEM_DIN2 = 32'h1122_3344; MEM_SIZE = 2'd2;
    @(posedge CLK); #1;
    n_chk++;
    if (MEM_BUSY !== MISAL || MEM_ERR !== !MISAL) begin
      n_fail++; $display("FAIL rst_split_enter: got busy=%b err=%b, expected %b %b", MEM_BUSY, MEM_ERR, MISAL, !MISAL);
    end
    RST = 1;
    @(posedge CLK); #1;
    n_chk++;
    if ({MEM_DOUT1, MEM_DOUT2, IOBUS_ADDR, IOBUS_OUT} !== 128'd0 || {MEM_BUSY, MEM_ERR, IOBUS_WR} !== 3'b000) begin
      n_fail++; $display("FAIL rst_split_outputs: got %h %h %h %h flags %b, expected all 0",
                         MEM_DOUT1, MEM_DOUT2, IOBUS_ADDR, IOBUS_OUT, {MEM_BUSY, MEM_ERR, IOBUS_WR});
    end
    @(negedge CLK);
    RST = 0; MEM_WE2 = 0;
    if (MISAL) begin
      mb[32'h501] = 8'h44; mb[32'h502] = 8'h33; mb[32'h503] = 8'h22;
    end
    p1_read(32'h504, d);
    n_chk++;
    if (d !== 32'h2222_2222) begin n_fail++; $display("FAIL rst_split_wordB: got %h, expected 22222222", d); end
    p1_read(32'h500, d);
    n_chk++;
    if (d !== m_word(32'h500)) begin n_fail++; $display("FAIL rst_split_wordA: got %h, expected %h", d, m_word(32'h500)); end
    access(0, 1, 32'h100, 0, 2'd2, 0, 0, 0, e, w, nb);
    n_chk++;
    if (MEM_DOUT2 !== 32'hDEAD_BEEF || nb != 0) begin
      n_fail++; $display("FAIL post_rst_read: got %h busy=%0d, expected DEADBEEF 0", MEM_DOUT2, nb);
    end
  endtask

  task automatic test_port1_rbw();
    logic e, w; int nb; logic [31:0] d;
    mwr(32'h600, 32'hCAFE_0001);
    access(1, 0, 32'h600, 32'hCAFE_0002, 2'd2, 0, 1, 32'h600, e, w, nb);
    n_chk++;
    if (MEM_DOUT1 !== 32'hCAFE_0001) begin n_fail++; $display("FAIL rbw_old: got %h, expected CAFE0001", MEM_DOUT1); end
    p1_read(32'h600, d);
    n_chk++;
    if (d !== 32'hCAFE_0002) begin n_fail++; $display("FAIL rbw_new: got %h, expected CAFE0002", d); end
    m_write(32'h600, 32'hCAFE_0002, 2'd2);
  endtask

  task automatic test_back_to_back();
    logic e, w; int nb;
    for (int i = 0; i < 8; i++) mwr(32'h2000 + 4 * i, $urandom());
    for (int i = 0; i < 8; i++) begin
      access(0, 1, 32'h2000 + 4 * i, 0, 2'd2, 0, 1, 32'h2000 + 4 * (7 - i), e, w, nb);
      n_chk++;
      if (MEM_DOUT2 !== m_word(32'h2000 + 4 * i) || MEM_DOUT1 !== m_word(32'h2000 + 4 * (7 - i)) || e !== 1'b0) begin
        n_fail++; $display("FAIL b2b[%0d]: got d2=%h d1=%h err=%b, expected %h %h 0", i, MEM_DOUT2, MEM_DOUT1, e,
                           m_word(32'h2000 + 4 * i), m_word(32'h2000 + 4 * (7 - i)));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_d1, exp_d2, addr, din, a1, iin, d;
    logic we, rd, uns, r1, e_s, w_s, io, exp_e, exp_w;
    logic [1:0] sz;
    int nb, kind, exp_nb;
    exp_d1 = 0; exp_d2 = 0;
    for (int i = 0; i < 64; i++) mwr(32'h1000 + 4 * i, $urandom());
    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 19);
      we = 1'($urandom_range(0, 1)); rd = 1'($urandom_range(0, 1));
      if (!we) rd = 1;
      if (i == 0) begin kind = 5; we = 0; rd = 1; end
      sz  = (kind == 1) ? 2'd3 : 2'($urandom_range(0, 2));
      uns = 1'($urandom_range(0, 1));
      din = $urandom();
      case (kind)
        0:       addr = IO_BASE + 4 * $urandom_range(0, 255);
        2:       addr = 32'h1_0000 + $urandom_range(0, 4095);
        default: addr = 32'h1000 + $urandom_range(0, 251);
      endcase
      r1 = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      a1 = 32'h1000 + 4 * $urandom_range(0, 63);
      iin = $urandom(); IOBUS_IN = iin;
      io = addr >= IO_BASE;
      exp_e = m_err(addr, sz);
      exp_w = we && io && !exp_e;
      exp_nb = (MISAL && !exp_e && !io && m_misal(addr, sz)) ? 1 : 0;
      if (r1) exp_d1 = m_word(a1);
      access(we, rd, addr, din, sz, uns, r1, a1, e_s, w_s, nb);
      n_chk++;
      if (e_s !== exp_e || nb != exp_nb || w_s !== exp_w) begin
        n_fail++; $display("FAIL rnd_flags[%0d] addr=%h sz=%0d we=%b: got err=%b busy=%0d wr=%b, expected %b %0d %b",
                           i, addr, sz, we, e_s, nb, w_s, exp_e, exp_nb, exp_w);
      end
      if (exp_w) begin
        n_chk++;
        if (IOBUS_ADDR !== addr || IOBUS_OUT !== din) begin
          n_fail++; $display("FAIL rnd_io[%0d]: got %h %h, expected %h %h", i, IOBUS_ADDR, IOBUS_OUT, addr, din);
        end
      end
      if (!exp_e && we && !io) m_write(addr, din, sz);
      if (rd && !we) exp_d2 = exp_e ? 32'd0 : io ? iin : m_read(addr, sz, uns);
      n_chk++;
      if (MEM_DOUT2 !== exp_d2 || MEM_DOUT1 !== exp_d1) begin
        n_fail++; $display("FAIL rnd_data[%0d] addr=%h sz=%0d uns=%b: got d2=%h d1=%h, expected %h %h",
                           i, addr, sz, uns, MEM_DOUT2, MEM_DOUT1, exp_d2, exp_d1);
      end
    end
    for (int i = 0; i < 64; i++) begin
      p1_read(32'h1000 + 4 * i, d);
      n_chk++;
      if (d !== m_word(32'h1000 + 4 * i)) begin
        n_fail++; $display("FAIL rnd_sweep[%0d]: got %h, expected %h", i, d, m_word(32'h1000 + 4 * i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_byte();
    test_half_merge();
    test_misalign();
    test_io();
    test_errors();
    test_rst_split();
    test_port1_rbw();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
